// File: rtl/elastic_pipe.sv
// Compacting elastic pipeline: DEPTH valid/ready register stages with
// per-stage kill, whole-pipe flush and per-stage observation taps.
module elastic_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   flush,
  input  logic [DEPTH-1:0]       kill_mask,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [CNTW-1:0]        count
);

  logic [DEPTH-1:0]            r_v;
  logic [DEPTH-1:0][WIDTH-1:0] r_d;

  logic [DEPTH-1:0]            w_ev;
  logic [DEPTH:0]              w_rdy;
  logic [DEPTH-1:0]            w_src_v;
  logic [DEPTH-1:0][WIDTH-1:0] w_src_d;
  logic [CNTW-1:0]             w_cnt;

  // Effective valid: killed, flushed or in-reset stages read as bubbles.
  always_comb begin
    w_ev = r_v & ~kill_mask & {DEPTH{~flush & reset}};
  end

  // Ready chain from the output back to the input; a bubble is always ready.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_rdy[i] = ~w_ev[i] | w_rdy[i+1];
    end
  end

  // Source of each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    w_src_v    = '0;
    w_src_d    = '0;
    w_src_v[0] = in_valid & in_ready;
    w_src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_v[i] = w_ev[i-1];
      w_src_d[i] = r_d[i-1];
    end
  end

  // Stage registers: advance when ready, otherwise hold and drop killed items.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_v <= '0;
      r_d <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_src_v[i];
          if (w_src_v[i]) begin
            r_d[i] <= w_src_d[i];
          end
        end else begin
          r_v[i] <= w_ev[i];
        end
      end
    end
  end

  // Occupancy is the popcount of the registered valid bits.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + CNTW'(r_v[i]);
    end
  end

  // Port drive: handshake, output stage and taps.
  always_comb begin
    in_ready    = w_rdy[0] & ~flush & reset;
    out_valid   = w_ev[DEPTH-1];
    out_data    = r_d[DEPTH-1];
    stage_valid = w_ev;
    stage_data  = r_d;
    count       = w_cnt;
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe (DEPTH=3, WIDTH=32).
module tb_elastic_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned CNTW  = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   flush;
  logic [DEPTH-1:0]       kill_mask;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic [CNTW-1:0]        count;

  int total = 0;
  int bad   = 0;

  elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush      (flush),
    .kill_mask  (kill_mask),
    .stage_valid(stage_valid),
    .stage_data (stage_data),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs may then be changed safely.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  // Fill the stalled pipe with a (st2), b (st1), c (st0).
  task automatic fill3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c);
    out_ready = 1'b0;
    offer(1'b1, a); step();
    offer(1'b1, b); step();
    offer(1'b1, c); step();
    offer(1'b0, '0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    kill_mask = '0;

    // 1. reset
    step(); step();
    settle();
    chk("rst_in_ready", 96'(in_ready), 96'd0);
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_count", 96'(count), 96'd0);
    chk("rst_stage_data", 96'(stage_data), 96'd0);
    reset = 1'b1;
    settle();
    chk("rel_in_ready", 96'(in_ready), 96'd1);

    // 2. latency and stream
    out_ready = 1'b1;
    offer(1'b1, 32'h11);
    settle();
    chk("lat_accept", 96'(in_ready), 96'd1);
    step();
    offer(1'b0, '0);
    step();
    settle();
    chk("lat_c2_empty", 96'(out_valid), 96'd0);
    step();
    settle();
    chk("lat_c3_valid", 96'(out_valid), 96'd1);
    chk("lat_c3_data", 96'(out_data), 96'h11);
    step();
    for (int k = 0; k < 19; k++) begin
      if (k < 16) offer(1'b1, 32'(32'h20 + k));
      else        offer(1'b0, '0);
      settle();
      chk("str_in_ready", 96'(in_ready), 96'd1);
      if (k >= 3) begin
        chk("str_valid", 96'(out_valid), 96'd1);
        chk("str_data", 96'(out_data), 96'(32'h20 + k - 3));
      end else begin
        chk("str_no_out", 96'(out_valid), 96'd0);
      end
      step();
    end
    settle();
    chk("str_drained", 96'(count), 96'd0);

    // 3. backpressure
    fill3(32'hA1, 32'hB2, 32'hC3);
    offer(1'b1, 32'hD4);
    settle();
    chk("bp_full_ready", 96'(in_ready), 96'd0);
    chk("bp_count", 96'(count), 96'd3);
    step();
    out_ready = 1'b1;
    settle();
    chk("bp_ready_comb", 96'(in_ready), 96'd1);
    chk("bp_out_a", 96'(out_data), 96'hA1);
    step();
    offer(1'b0, '0);
    settle();
    chk("bp_out_b", 96'(out_data), 96'hB2);
    step();
    settle();
    chk("bp_out_c", 96'(out_data), 96'hC3);
    step();
    settle();
    chk("bp_out_d_valid", 96'(out_valid), 96'd1);
    chk("bp_out_d", 96'(out_data), 96'hD4);
    step();
    settle();
    chk("bp_empty", 96'(out_valid), 96'd0);
    chk("bp_count0", 96'(count), 96'd0);

    // 4. bubble compaction
    out_ready = 1'b0;
    offer(1'b1, 32'h0A); step();
    offer(1'b0, '0);     step();
    offer(1'b1, 32'h0B); step();
    offer(1'b0, '0);     step();
    settle();
    chk("cmp_sv", 96'(stage_valid), 96'b110);
    chk("cmp_count", 96'(count), 96'd2);
    chk("cmp_in_ready", 96'(in_ready), 96'd1);
    chk("cmp_st2", 96'(stage_data[2*WIDTH +: WIDTH]), 96'h0A);
    chk("cmp_st1", 96'(stage_data[1*WIDTH +: WIDTH]), 96'h0B);
    out_ready = 1'b1;
    settle();
    chk("cmp_out_a", 96'(out_data), 96'h0A);
    step();
    settle();
    chk("cmp_out_b", 96'(out_data), 96'h0B);
    step();
    settle();
    chk("cmp_empty", 96'(count), 96'd0);

    // 5. kill middle stage
    fill3(32'hA5, 32'hB5, 32'hC5);
    kill_mask = 3'b010;
    settle();
    chk("kill_ev_now", 96'(stage_valid), 96'b101);
    step();
    kill_mask = '0;
    settle();
    chk("kill_sv", 96'(stage_valid), 96'b110);
    chk("kill_count", 96'(count), 96'd2);
    chk("kill_c_st1", 96'(stage_data[1*WIDTH +: WIDTH]), 96'hC5);
    out_ready = 1'b1;
    settle();
    chk("kill_out_a", 96'(out_data), 96'hA5);
    step();
    settle();
    chk("kill_out_c", 96'(out_data), 96'hC5);
    step();
    settle();
    chk("kill_empty", 96'(out_valid), 96'd0);

    // 6. flush
    fill3(32'hA6, 32'hB6, 32'hC6);
    offer(1'b1, 32'hE6);
    out_ready = 1'b1;
    flush     = 1'b1;
    kill_mask = 3'b111;
    settle();
    chk("fl_in_ready", 96'(in_ready), 96'd0);
    chk("fl_out_valid", 96'(out_valid), 96'd0);
    step();
    flush     = 1'b0;
    kill_mask = '0;
    offer(1'b0, '0);
    out_ready = 1'b0;
    settle();
    chk("fl_count", 96'(count), 96'd0);
    chk("fl_sv", 96'(stage_valid), 96'd0);
    chk("fl_data_kept", 96'(stage_data[2*WIDTH +: WIDTH]), 96'hA6);
    chk("fl_st0_kept", 96'(stage_data[0 +: WIDTH]), 96'hC6);

    // Reset mid-stream drops everything.
    out_ready = 1'b1;
    offer(1'b1, 32'h77); step();
    offer(1'b1, 32'h78); step();
    offer(1'b0, '0);
    reset = 1'b0;
    settle();
    chk("mrst_in_ready", 96'(in_ready), 96'd0);
    chk("mrst_out_valid", 96'(out_valid), 96'd0);
    step();
    reset = 1'b1;
    settle();
    chk("mrst_count", 96'(count), 96'd0);
    chk("mrst_data", 96'(stage_data), 96'd0);
    step(); step(); step();
    settle();
    chk("mrst_no_out", 96'(out_valid), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
Name: elastic_pipe

Overview:
Parametrised elastic pipeline of DEPTH register stages, WIDTH bits each, with valid/ready handshake on both ends. Stages are compacting: a stage holding a bubble accepts new content even when downstream is stalled. Supports per-stage kill and whole-pipe flush, replacing the fixed-enable, constant-flush floprc chains between datapath stages. Exposes per-stage valid/data taps for forwarding and hazard logic.

Parameters:
WIDTH, 32, payload bits per stage
DEPTH, 3, number of stages (1..8); stage 0 is input side, stage DEPTH-1 is output side
CNTW, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-low reset (0 = reset)
in_valid  in  1  upstream item present
in_ready  out  1  pipe accepts in_data this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  item available at output
out_ready  in  1  downstream accepts
out_data  out  WIDTH  output payload (= stage DEPTH-1 data)
flush  in  1  kill all stages, block input this cycle
kill_mask  in  DEPTH  per-stage kill, bit i = stage i
stage_valid  out  DEPTH  effective valid of each stage
stage_data  out  DEPTH*WIDTH  stage i data at bits [i*WIDTH +: WIDTH]
count  out  CNTW  number of registered valid stages

Behaviour:
- State: v[i] valid bit, d[i] WIDTH data, per stage. Reset (reset==0 at clk edge): all v=0, all d=0. While reset==0, in_ready=0 and out_valid=0.
- Effective valid: ev[i] = v[i] & ~kill_mask[i] & ~flush. A killed item is a bubble for this cycle and is dropped.
- stage_valid[i]=ev[i]; out_valid=ev[DEPTH-1]; out_data=d[DEPTH-1]; stage_data exposes d[i] unmodified.
- Ready chain (combinational): r[DEPTH]=out_ready; r[i]=~ev[i] | r[i+1]; in_ready=r[0] & ~flush & reset.
- Stage i enable en[i]=r[i]. When en[i]: v[i] <= source valid, where the source is in_valid&in_ready for i=0 and ev[i-1] otherwise. d[i] <= source data only when source valid; otherwise d[i] holds.
- When en[i]=0: v[i] <= ev[i], d[i] holds. A killed, non-advancing stage is therefore cleared.
- Output transfer occurs when out_valid & out_ready. Input transfer occurs when in_valid & in_ready.
- flush: no input or output transfer that cycle; all v=0 next cycle; d is unchanged.
- Simultaneous kill_mask and flush: flush dominates. kill_mask with advance: the killed item vanishes, and upstream items move into the gap in the same cycle.
- count = popcount(v) of the registered bits, not ev; updated the cycle after any change.
- Latency: empty pipe with out_ready=1. An item accepted in cycle t has out_valid=1 in cycle t+DEPTH. Throughput is 1 item/cycle sustained.
- Order: items leave in acceptance order. No duplication; no loss except through kill or flush.
- Full (all ev=1, out_ready=0): in_ready=0. Raising out_ready gives in_ready=1 in the same cycle; the ready path is combinational from out_ready.
- Empty: out_valid=0, count=0, in_ready=1 (absent flush and reset).
- Reset asserted mid-stream: all content is lost at the next edge; no partial output.
- DEPTH=1: degenerates to a single register with ready pass-through; the same rules apply.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, DEPTH=3 -> in_ready=0, out_valid=0, count=0, stage_data all 0. After release -> in_ready=1.
2. Latency/stream: out_ready=1, push 0x11 at cycle 0 -> out_valid=1 with out_data=0x11 at cycle 3. Then push 0x20..0x2F back-to-back -> 16 outputs in order on consecutive cycles, in_ready always 1.
3. Backpressure: out_ready=0, offer A,B,C,D -> A,B,C accepted, in_ready=0 while D is offered, count=3. Raise out_ready -> A out and D accepted in the same cycle; then B, C, D out in order.
4. Bubble compaction: out_ready=0. Push A, idle one cycle, push B -> A reaches stage 2, B reaches stage 1, count=2, in_ready=1, stage_valid=3'b110.
5. Kill: full pipe A(st2),B(st1),C(st0), out_ready=0, kill_mask=3'b010 for one cycle -> next cycle stage_valid=3'b110 with C in stage 1, count=2. Drain gives A then C.
6. Flush: full pipe, in_valid=1, out_ready=1, flush=1 for one cycle -> in_ready=0 and out_valid=0 that cycle; next cycle count=0, stage_valid=0. The offered item is not accepted.
